sdm_demod_scheduler: RTL and testbench
======================================

// Module: sdm_demod_scheduler
// PURPOSE
//  Sequencer and output arbiter for a bank of NUM_CH SDM demodulators.
//  - Generates the shared oversampling strobe dm_tick, driven onto every demodulator's valid_in.
//  - Captures each demodulator's decimated 16-bit sample into a holding register.
//  - Serialises the held samples, round-robin, onto one channel-tagged valid/ready stream for downstream audio.
// PARAMETERS
//  NUM_CH   4    number of demodulator channels (2..16)
//  CLK_DIV  4    clk cycles per dm_tick (1..65535; 1 = tick every enabled cycle)
// PORTS
//  clk        in   1            single clock; all logic on rising edge
//  rst        in   1            synchronous reset, active-high
//  enable     in   1            1 = run tick generator
//  dm_tick    out  1            one-cycle strobe to all demodulator valid_in
//  dm_valid   in   NUM_CH       per-channel demodulator valid_out pulse
//  dm_dout    in   NUM_CH*16    per-channel sample; channel i = bits [16i+15:16i]
//  out_valid  out  1            output sample valid
//  out_ready  in   1            downstream accepts when out_valid & out_ready
//  out_data   out  16           output sample
//  out_ch     out  CH_W         source channel, CH_W = $clog2(NUM_CH)
//  ovf_flag   out  NUM_CH       sticky per-channel overrun flag
//  ovf_clr    in   1            one-cycle pulse clears all ovf_flag bits
// BEHAVIOUR
//  Reset (rst=1 at an edge) clears all state:
//  - dm_tick=0, out_valid=0, out_data=0, out_ch=0, ovf_flag=0.
//  - Pending bits cleared and RR pointer=0; in-flight and held samples are dropped.
//  Tick generator:
//  - div_cnt counts 0..CLK_DIV-1 while enable=1.
//  - dm_tick is registered: high for exactly one cycle, in the cycle after div_cnt==CLK_DIV-1; then div_cnt wraps to 0.
//  - enable=0: div_cnt forced to 0 and no further ticks. Re-enable restarts the full CLK_DIV period.
//  Capture, channel i:
//  - dm_valid[i]=1 loads hold[i]<=dm_dout[i] and sets pend[i].
//  - If pend[i] is already set and not granted that cycle: overwrite with the new sample (newest wins) and set ovf_flag[i].
//  - Grant of i and new dm_valid[i] in the same cycle: the granted old sample goes out, the new one is held, pend[i] stays 1, no overflow.
//  Output FSM (IDLE, SEND):
//  - IDLE: out_valid=0. If any pend, grant the first pending channel at or after rr_ptr, scanning upward with wrap. Load out_data/out_ch, clear that pend bit, set rr_ptr=grant+1 (mod NUM_CH), go to SEND.
//  - SEND: out_valid=1. out_data and out_ch stay stable while out_ready=0.
//  - On handshake in SEND: if another channel is pending, grant it in the same cycle and stay in SEND (back-to-back, no bubble); otherwise go to IDLE.
//  Latency and throughput:
//  - Minimum latency: dm_valid at cycle t, out_valid at t+2.
//  - Throughput: 1 sample/clk.
//  ovf_flag:
//  - Cleared by ovf_clr.
//  - A set and ovf_clr on the same bit in the same cycle: set wins.
//  Widths: samples pass unmodified as 16-bit two's complement; no arithmetic is applied.
// CONFIGURATION
//  SDM_SCHED_OVF_CNT_EN
//  - Defined: adds output port ovf_cnt [NUM_CH*8] with one 8-bit counter per channel.
//    Each counter increments on every overrun and saturates at 255.
//    Counters are cleared by rst and by ovf_clr; if an increment and ovf_clr coincide, the result is 1.
//  - Undefined: port and counters are absent; only ovf_flag is provided.
// STRUCTURE
//  Package sdm_pkg:
//  - localparam SDM_W=16
//  - typedef logic signed [SDM_W-1:0] sdm_sample_t
//  - typedef enum logic {SCH_IDLE, SCH_SEND} sch_state_t
//  Sub-module sdm_rr_arbiter (NUM_CH):
//  - inputs: req vector, ptr
//  - outputs: grant index, any
//  - combinational; instantiated once.
//  Tick generator, holding registers and FSM are in this module.
// TESTING (NUM_CH=4, CLK_DIV=4)
//  1. rst, enable=1 for 20 clk -> dm_tick high exactly 5 cycles, 4 apart; enable=0 mid-period -> no tick and div_cnt=0.
//  2. dm_valid[2] with 0x7FFF, out_ready=1 -> out_valid 2 cycles later, out_data=0x7FFF, out_ch=2, one beat.
//  3. dm_valid=4'b1111 with 0x1111/0x2222/0x3333/0x4444, out_ready=1 -> 4 consecutive beats, ch 0,1,2,3; next sample on ch0 only -> ch0.
//  4. out_ready=0 and ch1 sent twice (0x0001 then 0x0002) -> held data stable, ovf_flag[1]=1; release ready -> ch1 output 0x0002 then no more; ovf_clr -> flag 0.
//  5. Grant and new dm_valid[3] in the same cycle -> both samples delivered in order, ovf_flag[3]=0.
//  6. rst while SEND with 3 pending -> next cycle out_valid=0 and no stale beats afterwards; with SDM_SCHED_OVF_CNT_EN, 300 overruns on ch0 -> ovf_cnt[7:0]=255.

Source files
------------

// File: rtl/sdm_demod_scheduler_pkg.sv
// Shared types for the SDM demodulator scheduler: sample width, sample type
// and the output-FSM state encoding.
package sdm_pkg;

    localparam int SDM_W = 16;

    typedef logic signed [SDM_W-1:0] sdm_sample_t;

    typedef enum logic {
        SCH_IDLE,
        SCH_SEND
    } sch_state_t;

endpackage

// File: rtl/sdm_demod_scheduler_if.sv
// Channel-tagged valid/ready output stream carrying demodulated samples.
// master = scheduler side, slave = downstream consumer.
interface sdm_demod_scheduler_if
    import sdm_pkg::*;
#(
    parameter int NUM_CH = 4
) ();

    localparam int CH_W = $clog2(NUM_CH);

    logic              out_valid;
    logic              out_ready;
    sdm_sample_t       out_data;
    logic [CH_W-1:0]   out_ch;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
    );

endinterface

// File: rtl/sdm_demod_scheduler_arbiter.sv
// Combinational round-robin picker: returns the first requesting channel at or
// after ptr, scanning upward and wrapping at NUM_CH.
module sdm_rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any
);

    // Scan offsets from the far end down so the nearest requester wins last.
    always_comb begin
        int idx;
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (req[idx]) begin
                grant = CH_W'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdm_demod_scheduler.sv
// Sequencer and output arbiter for a bank of SDM demodulators: shared tick
// generation, per-channel sample capture and round-robin serialisation onto
// one valid/ready stream.
// Optional feature macro: SDM_SCHED_OVF_CNT_EN adds per-channel saturating
// 8-bit overrun counters on port ovf_cnt.
module sdm_demod_scheduler
    import sdm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CLK_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    dm_tick,
    input  logic [NUM_CH-1:0]       dm_valid,
    input  logic [NUM_CH*SDM_W-1:0] dm_dout,
    sdm_demod_scheduler_if.master   out_if,
    output logic [NUM_CH-1:0]       ovf_flag,
    input  logic                    ovf_clr
`ifdef SDM_SCHED_OVF_CNT_EN
    ,
    output logic [NUM_CH*8-1:0]     ovf_cnt
`endif
);

    localparam int          CH_W     = $clog2(NUM_CH);
    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0]       div_cnt_reg;
    logic              dm_tick_reg;

    sdm_sample_t       hold_reg [NUM_CH];
    logic [NUM_CH-1:0] pend_reg, pend_next;
    logic [NUM_CH-1:0] ovf_flag_reg, ovf_flag_next;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] grant_onehot;

    sch_state_t        state_reg, state_next;
    logic [CH_W-1:0]   rr_ptr_reg, rr_ptr_next;
    sdm_sample_t       out_data_reg;
    logic [CH_W-1:0]   out_ch_reg;

    logic [CH_W-1:0]   grant_idx;
    logic              grant_any;
    logic              handshake;
    logic              grant_fire;

    // Tick generator: registered strobe one cycle after the last count of a period.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            div_cnt_reg <= '0;
            dm_tick_reg <= 1'b0;
        end else begin
            dm_tick_reg <= (div_cnt_reg == DIV_LAST);
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + 16'd1;
        end
    end

    assign dm_tick = dm_tick_reg;

    sdm_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arbiter (
        .req    (pend_reg),
        .ptr    (rr_ptr_reg),
        .grant  (grant_idx),
        .any    (grant_any)
    );

    // Per-channel pending/overrun next-state; a new sample always leaves pend set.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign ovf_set[gi]       = dm_valid[gi] & pend_reg[gi] & ~grant_onehot[gi];
            assign pend_next[gi]     = dm_valid[gi] | (pend_reg[gi] & ~grant_onehot[gi]);
            assign ovf_flag_next[gi] = ovf_set[gi] | (ovf_flag_reg[gi] & ~ovf_clr);
        end
    endgenerate

    // Holding registers, pending bits and sticky overrun flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg     <= '0;
            ovf_flag_reg <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                hold_reg[i] <= '0;
            end
        end else begin
            pend_reg     <= pend_next;
            ovf_flag_reg <= ovf_flag_next;
            for (int i = 0; i < NUM_CH; i++) begin
                if (dm_valid[i]) begin
                    hold_reg[i] <= dm_dout[i*SDM_W +: SDM_W];
                end
            end
        end
    end

    assign ovf_flag = ovf_flag_reg;

`ifdef SDM_SCHED_OVF_CNT_EN
    logic [7:0] cnt_reg  [NUM_CH];
    logic [7:0] cnt_next [NUM_CH];

    // Saturating overrun counters; a coincident clear and overrun leaves 1.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cnt
            assign cnt_next[gi] = ovf_set[gi]
                                ? (ovf_clr ? 8'd1 : ((cnt_reg[gi] == 8'hFF) ? 8'hFF : cnt_reg[gi] + 8'd1))
                                : (ovf_clr ? 8'd0 : cnt_reg[gi]);
            assign ovf_cnt[gi*8 +: 8] = cnt_reg[gi];
        end
    endgenerate

    // Counter state update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_reg[i] <= rst ? 8'd0 : cnt_next[i];
        end
    end
`endif

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SCH_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Output FSM next-state: stay in SEND across back-to-back grants.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            SCH_IDLE: if (grant_any) state_next = SCH_SEND;
            SCH_SEND: if (out_if.out_ready && !grant_any) state_next = SCH_IDLE;
            default:  state_next = SCH_IDLE;
        endcase
    end

    // Output FSM outputs: grant on entry from IDLE or on a completed beat.
    always_comb begin
        handshake    = (state_reg == SCH_SEND) && out_if.out_ready;
        grant_fire   = grant_any && ((state_reg == SCH_IDLE) || handshake);
        grant_onehot = '0;
        if (grant_fire) begin
            grant_onehot[grant_idx] = 1'b1;
        end
        rr_ptr_next  = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    end

    // Output data/channel registers and round-robin pointer, loaded on grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_reg <= '0;
            out_ch_reg   <= '0;
            rr_ptr_reg   <= '0;
        end else if (grant_fire) begin
            out_data_reg <= hold_reg[grant_idx];
            out_ch_reg   <= grant_idx;
            rr_ptr_reg   <= rr_ptr_next;
        end
    end

    assign out_if.out_valid = (state_reg == SCH_SEND);
    assign out_if.out_data  = out_data_reg;
    assign out_if.out_ch    = out_ch_reg;

endmodule

// File: tb/tb_sdm_demod_scheduler.sv
// Directed, table-driven bench for sdm_demod_scheduler (NUM_CH=4, CLK_DIV=4).
module tb_sdm_demod_scheduler;
    import sdm_pkg::*;

    localparam int NUM_CH  = 4;
    localparam int CLK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        dm_tick;
    logic [3:0]  dm_valid;
    logic [63:0] dm_dout;
    logic [3:0]  ovf_flag;
    logic        ovf_clr;
`ifdef SDM_SCHED_OVF_CNT_EN
    logic [31:0] ovf_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    sdm_demod_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

    sdm_demod_scheduler #(
        .NUM_CH   (NUM_CH),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .dm_tick  (dm_tick),
        .dm_valid (dm_valid),
        .dm_dout  (dm_dout),
        .out_if   (bus.master),
        .ovf_flag (ovf_flag),
        .ovf_clr  (ovf_clr)
`ifdef SDM_SCHED_OVF_CNT_EN
        ,
        .ovf_cnt  (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rs;
        logic [3:0]  v;
        logic [63:0] dout;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  ec;
        logic [3:0]  ef;
    } vec_t;

    vec_t vt [36];

    function automatic vec_t mk(input logic rs, input logic [3:0] v, input logic [63:0] dout,
                                input logic rdy, input logic clr, input logic ev,
                                input logic [15:0] ed, input logic [1:0] ec, input logic [3:0] ef);
        vec_t r;
        r.rs = rs; r.v = v; r.dout = dout; r.rdy = rdy; r.clr = clr;
        r.ev = ev; r.ed = ed; r.ec = ec; r.ef = ef;
        return r;
    endfunction

    task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row=%0d got=0x%0h want=0x%0h", nm, row, act, exp);
        end else begin
            $display("ok   %s row=%0d value=0x%0h", nm, row, act);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; dm_valid = '0; dm_dout = '0; ovf_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; dm_valid = '0; dm_dout = '0; ovf_clr = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply_row(input vec_t r, input int idx);
        @(negedge clk);
        rst = r.rs; dm_valid = r.v; dm_dout = r.dout; bus.out_ready = r.rdy; ovf_clr = r.clr;
        @(posedge clk); #1;
        chk("out_valid", idx, {15'd0, bus.out_valid}, {15'd0, r.ev});
        chk("out_data",  idx, bus.out_data, r.ed);
        chk("out_ch",    idx, {14'd0, bus.out_ch}, {14'd0, r.ec});
        chk("ovf_flag",  idx, {12'd0, ovf_flag}, {12'd0, r.ef});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks;
        int tick_pos [5];
        int first_tick;
        int beats;

        rst = 1'b1; enable = 1'b0; dm_valid = '0; dm_dout = '0; ovf_clr = 1'b0;
        bus.out_ready = 1'b0;

        // Vector table: rows are {inputs this cycle, outputs after the edge}.
        vt[0]  = mk(1, 4'b0000, 64'h0,                     1, 0, 0, 16'h0000, 0, 4'b0000);
        vt[1]  = mk(0, 4'b0100, 64'h0000_7FFF_0000_0000,   1, 0, 0, 16'h0000, 0, 4'b0000);
        vt[2]  = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h7FFF, 2, 4'b0000);
        vt[3]  = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h7FFF, 2, 4'b0000);
        vt[4]  = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h7FFF, 2, 4'b0000);
        vt[5]  = mk(1, 4'b0000, 64'h0,                     1, 0, 0, 16'h0000, 0, 4'b0000);
        vt[6]  = mk(0, 4'b1111, 64'h4444_3333_2222_1111,   1, 0, 0, 16'h0000, 0, 4'b0000);
        vt[7]  = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h1111, 0, 4'b0000);
        vt[8]  = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h2222, 1, 4'b0000);
        vt[9]  = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h3333, 2, 4'b0000);
        vt[10] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h4444, 3, 4'b0000);
        vt[11] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h4444, 3, 4'b0000);
        vt[12] = mk(0, 4'b0001, 64'h0000_0000_0000_AAAA,   1, 0, 0, 16'h4444, 3, 4'b0000);
        vt[13] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'hAAAA, 0, 4'b0000);
        vt[14] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'hAAAA, 0, 4'b0000);
        vt[15] = mk(0, 4'b0001, 64'h0000_0000_0000_5555,   0, 0, 0, 16'hAAAA, 0, 4'b0000);
        vt[16] = mk(0, 4'b0010, 64'h0000_0000_0001_0000,   0, 0, 1, 16'h5555, 0, 4'b0000);
        vt[17] = mk(0, 4'b0010, 64'h0000_0000_0002_0000,   0, 0, 1, 16'h5555, 0, 4'b0010);
        vt[18] = mk(0, 4'b0000, 64'h0,                     0, 0, 1, 16'h5555, 0, 4'b0010);
        vt[19] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h0002, 1, 4'b0010);
        vt[20] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h0002, 1, 4'b0010);
        vt[21] = mk(0, 4'b0000, 64'h0,                     1, 1, 0, 16'h0002, 1, 4'b0000);
        vt[22] = mk(0, 4'b1000, 64'h1234_0000_0000_0000,   1, 0, 0, 16'h0002, 1, 4'b0000);
        vt[23] = mk(0, 4'b1000, 64'h5678_0000_0000_0000,   1, 0, 1, 16'h1234, 3, 4'b0000);
        vt[24] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h5678, 3, 4'b0000);
        vt[25] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h5678, 3, 4'b0000);
        vt[26] = mk(0, 4'b0100, 64'h0000_0A0A_0000_0000,   0, 0, 0, 16'h5678, 3, 4'b0000);
        vt[27] = mk(0, 4'b0100, 64'h0000_0B0B_0000_0000,   0, 0, 1, 16'h0A0A, 2, 4'b0000);
        vt[28] = mk(0, 4'b0100, 64'h0000_8000_0000_0000,   0, 1, 1, 16'h0A0A, 2, 4'b0100);
        vt[29] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h8000, 2, 4'b0100);
        vt[30] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h8000, 2, 4'b0100);
        vt[31] = mk(0, 4'b0000, 64'h0,                     1, 1, 0, 16'h8000, 2, 4'b0000);
        vt[32] = mk(0, 4'b1001, 64'h0300_0000_0000_0100,   1, 0, 0, 16'h8000, 2, 4'b0000);
        vt[33] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h0300, 3, 4'b0000);
        vt[34] = mk(0, 4'b0000, 64'h0,                     1, 0, 1, 16'h0100, 0, 4'b0000);
        vt[35] = mk(0, 4'b0000, 64'h0,                     1, 0, 0, 16'h0100, 0, 4'b0000);

        // Tick generator: 20 enabled cycles give ticks on edges 4, 8, 12, 16, 20.
        do_reset();
        chk("reset_tick", 0, {15'd0, dm_tick}, 16'd0);
        enable = 1'b1;
        ticks = 0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (dm_tick) begin
                if (ticks < 5) tick_pos[ticks] = e;
                ticks++;
            end
        end
        chk("tick_count", 0, 16'(ticks), 16'd5);
        for (int k = 0; k < 5; k++) begin
            chk("tick_pos", k, 16'(tick_pos[k]), 16'(4 * (k + 1)));
        end
        // Disable mid-period, then re-enable: the next tick needs a full period.
        @(posedge clk); @(posedge clk);
        @(negedge clk); enable = 1'b0;
        ticks = 0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            if (dm_tick) ticks++;
        end
        chk("tick_disabled", 0, 16'(ticks), 16'd0);
        @(negedge clk); enable = 1'b1;
        first_tick = 0;
        for (int e = 1; e <= 6; e++) begin
            @(posedge clk); #1;
            if (dm_tick && first_tick == 0) first_tick = e;
        end
        chk("tick_restart", 0, 16'(first_tick), 16'd4);
        @(negedge clk); enable = 1'b0;

        // Table-driven datapath vectors.
        for (int i = 0; i < 36; i++) begin
            apply_row(vt[i], i);
        end
        @(negedge clk); idle_inputs();

        // Reset while SEND with three channels still pending.
        do_reset();
        @(negedge clk); bus.out_ready = 1'b0; dm_valid = 4'b1111; dm_dout = 64'hDDDD_CCCC_BBBB_AAAA;
        @(posedge clk); #1;
        @(negedge clk); dm_valid = '0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 0, {15'd0, bus.out_valid}, 16'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 0, {15'd0, bus.out_valid}, 16'd0);
        chk("rst_data",  0, bus.out_data, 16'd0);
        chk("rst_ch",    0, {14'd0, bus.out_ch}, 16'd0);
        @(negedge clk); rst = 1'b0; bus.out_ready = 1'b1;
        beats = 0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (bus.out_valid) beats++;
        end
        chk("stale_beats", 0, 16'(beats), 16'd0);

`ifdef SDM_SCHED_OVF_CNT_EN
        // Continuous ch0 samples with the output stalled: the first two cycles
        // capture and grant, every later one is an overrun.
        do_reset();
        @(negedge clk); bus.out_ready = 1'b0; dm_valid = 4'b0001; dm_dout = 64'h1;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
        end
        chk("ovf_cnt_10", 0, {8'd0, ovf_cnt[7:0]}, 16'd10);
        for (int e = 0; e < 298; e++) begin
            @(posedge clk); #1;
        end
        chk("ovf_cnt_sat", 0, {8'd0, ovf_cnt[7:0]}, 16'd255);
        chk("ovf_cnt_ch1", 0, {8'd0, ovf_cnt[15:8]}, 16'd0);
        @(negedge clk); ovf_clr = 1'b1;
        @(posedge clk); #1;
        chk("ovf_cnt_clr_inc", 0, {8'd0, ovf_cnt[7:0]}, 16'd1);
        @(negedge clk); dm_valid = '0;
        @(posedge clk); #1;
        chk("ovf_cnt_clr", 0, {8'd0, ovf_cnt[7:0]}, 16'd0);
        @(negedge clk); idle_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
